// File: rtl/ip_hdr_tx.sv
// ip_hdr_tx -- IPv4 header generator for the TX path.
//
// Takes one request at a time (source/destination address, protocol and
// payload length). It builds the 20-byte IPv4 header, adds up the header
// checksum one 16-bit word per cycle, and then streams the header out
// DATA_BYTES bytes per beat. The output honours valid/ready backpressure.
// An Identification counter advances once for each header that is fully sent.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_sa, req_da        source / destination IPv4 address
//   req_proto             protocol byte
//   req_plen              payload length in bytes (header excluded)
//   len_err               one-cycle pulse: request dropped, total length overflow
//   m_valid/m_ready       header beat handshake
//   m_data                header bytes; the first byte on the wire is in m_data[7:0]
//   m_last                final header beat
//   ident                 Identification value the next header will carry
module ip_hdr_tx #(
  parameter int          DATA_BYTES = 1,
  parameter logic [7:0]  TTL        = 8'd64,
  parameter logic        DF         = 1'b1,
  parameter logic [15:0] IDENT_INIT = 16'h0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_sa,
  input  logic [31:0]             req_da,
  input  logic [7:0]              req_proto,
  input  logic [15:0]             req_plen,
  output logic                    len_err,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [8*DATA_BYTES-1:0] m_data,
  output logic                    m_last,
  output logic [15:0]             ident
);

  localparam int DW     = 8 * DATA_BYTES;
  localparam int NBEATS = 20 / DATA_BYTES;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FOLD = 2'd2;
  localparam logic [1:0] S_SEND = 2'd3;

  // Largest payload length for which the total length still fits in 16 bits.
  localparam logic [15:0] PLEN_MAX = 16'd65515;

  logic [1:0]   state;
  logic         rdy_en;
  logic [31:0]  sa_q;
  logic [31:0]  da_q;
  logic [7:0]   proto_q;
  logic [15:0]  tl_q;
  logic [15:0]  id_q;
  logic [15:0]  ck_q;
  logic [15:0]  ident_q;
  logic [19:0]  acc;
  logic [3:0]   cnt;
  logic [4:0]   beat;

  logic [15:0]  ck_sel;
  logic [159:0] hdr_flat;
  logic [15:0]  calc_word;
  logic [19:0]  fold1;
  logic [15:0]  fold2;
  logic [15:0]  ck_calc;
  logic [4:0]   beat_sel;
  logic [DW-1:0] nxt_data;

  // req_ready stays low while reset is held. It rises on the first clock
  // after release, because rdy_en is a register that resets to 0.
  assign req_ready = rdy_en && (state == S_IDLE);
  assign ident     = ident_q;

  // Checksum fold. The accumulator can carry up to 4 bits above bit 15.
  // After the first fold the value is at most 0x1000E, so a second fold
  // always fits in 16 bits.
  assign fold1   = {4'b0, acc[15:0]} + {16'b0, acc[19:16]};
  assign fold2   = fold1[15:0] + {12'b0, fold1[19:16]};
  assign ck_calc = ~fold2;

  // NOTE: every signal assigned in an always_comb gets a value on every path
  // (here, unconditionally first) so no latch is inferred.
  always_comb begin
    // In FOLD the checksum is not registered yet, so the first beat uses the
    // freshly computed value. During CALC ck_q is held at 0. That makes the
    // checksum field count as zero in the running sum.
    ck_sel = (state == S_FOLD) ? ck_calc : ck_q;

    // Byte i of the header sits at hdr_flat[8*i +: 8]. The list below runs
    // from byte 19 down to byte 0.
    hdr_flat = {da_q[7:0],  da_q[15:8],  da_q[23:16], da_q[31:24],
                sa_q[7:0],  sa_q[15:8],  sa_q[23:16], sa_q[31:24],
                ck_sel[7:0], ck_sel[15:8], proto_q,   TTL,
                8'h00,      {1'b0, DF, 6'b0}, id_q[7:0], id_q[15:8],
                tl_q[7:0],  tl_q[15:8],  8'h00,       8'h45};

    // Header word cnt: byte 2*cnt is the high byte, byte 2*cnt+1 the low byte.
    calc_word = {hdr_flat[int'(cnt)*16 +: 8], hdr_flat[int'(cnt)*16 + 8 +: 8]};

    // Next beat to load: beat 0 when leaving FOLD, otherwise the one after
    // the current beat.
    beat_sel = (state == S_FOLD) ? 5'd0 : beat + 5'd1;
    nxt_data = hdr_flat[int'(beat_sel)*DW +: DW];
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together on the clock edge, whatever order the statements
  // are written in.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the captured request fields are reset along with the control
    // state. The header byte mux and the outputs therefore never carry X
    // after reset, even before the first request arrives.
    if (!rst_n) begin
      state   <= S_IDLE;
      rdy_en  <= 1'b0;
      sa_q    <= '0;
      da_q    <= '0;
      proto_q <= '0;
      tl_q    <= '0;
      id_q    <= '0;
      ck_q    <= '0;
      ident_q <= IDENT_INIT;
      acc     <= '0;
      cnt     <= '0;
      beat    <= '0;
      len_err <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else begin
      rdy_en  <= 1'b1;
      len_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            if (req_plen > PLEN_MAX) begin
              // Total length would overflow. Drop the request and stay in IDLE.
              len_err <= 1'b1;
            end else begin
              sa_q    <= req_sa;
              da_q    <= req_da;
              proto_q <= req_proto;
              tl_q    <= req_plen + 16'd20;
              id_q    <= ident_q;
              ck_q    <= '0;
              acc     <= '0;
              cnt     <= '0;
              state   <= S_CALC;
            end
          end
        end

        S_CALC: begin
          acc <= acc + {4'b0, calc_word};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd9) state <= S_FOLD;
        end

        S_FOLD: begin
          ck_q    <= ck_calc;
          m_data  <= nxt_data;
          m_valid <= 1'b1;
          m_last  <= 1'b0;
          beat    <= '0;
          state   <= S_SEND;
        end

        S_SEND: begin
          if (m_ready) begin
            if (m_last) begin
              m_valid <= 1'b0;
              m_data  <= '0;
              m_last  <= 1'b0;
              ident_q <= ident_q + 16'd1;
              state   <= S_IDLE;
            end else begin
              beat   <= beat + 5'd1;
              m_data <= nxt_data;
              m_last <= (beat == 5'(NBEATS - 2));
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_hdr_tx.sv
// Testbench for ip_hdr_tx (DATA_BYTES=2, IDENT_INIT=16'hFFFF).
// A reference model computes each header byte list and its checksum directly
// from the header rules. The expected beats go into a queue, and a monitor
// compares every presented beat against the front of that queue.
module tb_ip_hdr_tx;

  localparam int          DB  = 2;
  localparam int          DW  = 8 * DB;
  localparam int          NB  = 20 / DB;
  localparam logic [15:0] ID0 = 16'hFFFF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_sa;
  logic [31:0]   req_da;
  logic [7:0]    req_proto;
  logic [15:0]   req_plen;
  logic          len_err;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [15:0]   ident;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t       sb[$];
  int          n_cmp     = 0;
  int          n_bad     = 0;
  int          beats_acc = 0;
  logic [15:0] model_ident;
  bit          rand_ready = 1'b0;

  ip_hdr_tx #(
    .DATA_BYTES(DB),
    .TTL       (8'd64),
    .DF        (1'b1),
    .IDENT_INIT(ID0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_sa   (req_sa),
    .req_da   (req_da),
    .req_proto(req_proto),
    .req_plen (req_plen),
    .len_err  (len_err),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .ident    (ident)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the header as a list of bytes, then the ones-complement
  // sum with end-around carry, then the bytes sliced into output beats.
  function automatic void push_expected(input logic [31:0] sa, input logic [31:0] da,
                                        input logic [7:0] proto, input logic [15:0] plen,
                                        input logic [15:0] id);
    logic [7:0]  h[20];
    int unsigned sum;
    logic [15:0] tl;
    logic [15:0] ck;
    beat_t       b;
    tl = plen + 16'd20;
    h = '{8'h45, 8'h00, tl[15:8], tl[7:0], id[15:8], id[7:0], 8'h40, 8'h00,
          8'd64, proto, 8'h00, 8'h00,
          sa[31:24], sa[23:16], sa[15:8], sa[7:0],
          da[31:24], da[23:16], da[15:8], da[7:0]};
    sum = 0;
    for (int i = 0; i < 10; i++) sum += {h[2*i], h[2*i+1]};
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    ck = ~16'(sum);
    h[10] = ck[15:8];
    h[11] = ck[7:0];
    for (int k = 0; k < NB; k++) begin
      b.data = '0;
      for (int j = 0; j < DB; j++) b.data[8*j +: 8] = h[k*DB + j];
      b.last = (k == NB - 1);
      sb.push_back(b);
    end
  endfunction

  // Monitor: compares each presented beat with the front of the queue. The
  // entry is popped only on a handshake, so any beat that changes during a
  // stall is caught as a mismatch.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && m_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got m_data %0h with no header outstanding (t=%0t)", m_data, $time);
        end else begin
          check("m_data", 64'(m_data), 64'(sb[0].data));
          check("m_last", 64'(m_last), 64'(sb[0].last));
          if (m_ready) begin
            void'(sb.pop_front());
            beats_acc++;
          end
        end
      end
    end
  end

  // m_ready changes just after each rising edge.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Present one request at a falling edge and hold it through the next
  // rising edge, which is the handshake edge. Returns 1 after that edge + 1.
  task automatic issue(input logic [31:0] sa, input logic [31:0] da, input logic [7:0] proto,
                       input logic [15:0] plen, output bit ok);
    int t;
    ok = 1'b0;
    t  = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (req_ready !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_ready_timeout: got %b expected 1", req_ready);
      return;
    end
    req_valid = 1'b1;
    req_sa    = sa;
    req_da    = da;
    req_proto = proto;
    req_plen  = plen;
    if (plen <= 16'd65515) push_expected(sa, da, proto, plen, model_ident);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    ok = 1'b1;
  endtask

  task automatic run_pkt(input logic [31:0] sa, input logic [31:0] da, input logic [7:0] proto,
                         input logic [15:0] plen);
    bit ok;
    int lat;
    int t;
    issue(sa, da, proto, plen, ok);
    if (!ok) return;
    // m_valid must become visible 11 edges after the handshake edge, that is
    // in cycle 12 when the accept cycle is counted as cycle 0.
    lat = 0;
    while (m_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'd11);
    t = 0;
    while (sb.size() != 0 && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pkt_timeout: got %0d beats outstanding expected 0", sb.size());
      return;
    end
    model_ident = model_ident + 16'd1;
    check("ident_after_pkt", 64'(ident), 64'(model_ident));
    check("req_ready_after_pkt", 64'(req_ready), 64'd1);
    check("m_valid_after_pkt", 64'(m_valid), 64'd0);
  endtask

  initial begin
    bit          ok;
    int          base;
    int          t;
    logic [15:0] bad_plen[2];

    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_sa      = '0;
    req_da      = '0;
    req_proto   = '0;
    req_plen    = '0;
    model_ident = ID0;

    // Values held during reset.
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_m_valid",   64'(m_valid),   64'd0);
    check("rst_m_data",    64'(m_data),    64'd0);
    check("rst_m_last",    64'(m_last),    64'd0);
    check("rst_len_err",   64'(len_err),   64'd0);
    check("rst_ident",     64'(ident),     64'(ID0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("req_ready_after_release", 64'(req_ready), 64'd1);

    // Reference packet, then a second packet so the ID wraps from FFFF to 0000.
    run_pkt(32'hC0A80001, 32'hC0A800C7, 8'h11, 16'd95);
    run_pkt(32'hC0A80001, 32'hC0A800C7, 8'h11, 16'd95);
    // Length boundaries.
    run_pkt(32'h0A000001, 32'h0A000002, 8'h06, 16'd0);
    run_pkt(32'hFFFFFFFF, 32'hFFFFFFFF, 8'hFF, 16'd65515);

    // Overflowing lengths are rejected.
    bad_plen[0] = 16'd65516;
    bad_plen[1] = 16'hFFFF;
    for (int i = 0; i < 2; i++) begin
      issue(32'h01020304, 32'h05060708, 8'h11, bad_plen[i], ok);
      if (ok) begin
        check("len_err_pulse",      64'(len_err),   64'd1);
        check("len_err_no_valid",   64'(m_valid),   64'd0);
        check("len_err_ident",      64'(ident),     64'(model_ident));
        check("len_err_req_ready",  64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        check("len_err_single",     64'(len_err),   64'd0);
        check("len_err_ready_next", 64'(req_ready), 64'd1);
      end
    end

    // Random requests with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 10; i++)
      run_pkt($urandom, $urandom, 8'($urandom), 16'($urandom_range(0, 65515)));
    rand_ready = 1'b0;

    // Reset while beat 3 (index 2) is on the output.
    issue(32'hAC100001, 32'hAC1000FE, 8'h11, 16'd512, ok);
    if (ok) begin
      base = beats_acc;
      t    = 0;
      while (beats_acc < base + 2 && t < 100) begin
        @(posedge clk);
        t++;
      end
      check("abort_beats_before_reset", 64'(beats_acc - base), 64'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_m_valid",   64'(m_valid),   64'd0);
      check("abort_m_data",    64'(m_data),    64'd0);
      check("abort_m_last",    64'(m_last),    64'd0);
      check("abort_req_ready", 64'(req_ready), 64'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      model_ident = ID0;
      @(posedge clk);
      #1;
      check("abort_ident",     64'(ident),     64'(ID0));
      check("abort_ready_rel", 64'(req_ready), 64'd1);
      check("abort_no_valid",  64'(m_valid),   64'd0);
      run_pkt(32'hC0A80001, 32'hC0A800C7, 8'h11, 16'd95);
    end

    repeat (5) @(posedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ip_hdr_tx.md
Name: ip_hdr_tx

Overview:
- Parametrised IPv4 header generator for the TX path.
- Accepts a per-packet request (addresses, protocol, payload length) over a valid/ready handshake, computes the header checksum sequentially, then streams the 20-byte header DATA_BYTES per beat with backpressure.
- Maintains a per-packet Identification counter.
- Sits between the TCP/UDP segment builder and the Ethernet frame encoder.

Parameters:
- DATA_BYTES, 1, output beat width in bytes; legal values 1, 2, 4 (must divide 20).
- TTL, 64, Time-to-Live byte.
- DF, 1, Don't-Fragment flag value; MF and fragment offset are always 0.
- IDENT_INIT, 16'h0000, Identification value of the first header after reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_sa  in  32  source IPv4 address
- req_da  in  32  destination IPv4 address
- req_proto  in  8  protocol field
- req_plen  in  16  payload length in bytes (excludes header)
- len_err  out  1  one-cycle pulse: request rejected, total length overflow
- m_valid  out  1  header beat valid
- m_ready  in  1  downstream accepts beat
- m_data  out  8*DATA_BYTES  header bytes; first wire byte in m_data[7:0]
- m_last  out  1  final header beat
- ident  out  16  Identification value used by the next header

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; req_ready=0 while asserted, 1 on the first clock after release; m_valid=0; m_data=0; m_last=0; len_err=0; ident=IDENT_INIT; accumulator=0. Reset mid-packet aborts with no partial output afterwards.
- Header layout (wire order):
  - 45 00, TL[15:8] TL[7:0], ID[15:8] ID[7:0]
  - {0,DF,0,5'b0} 00, TTL proto, CK[15:8] CK[7:0]
  - SA (4 bytes, MSB first), DA (4 bytes, MSB first)
  - TL = req_plen + 20.
- Request capture: on req_valid && req_ready, register sa, da, proto, TL and the current ident.
  - If req_plen > 65515: no header is produced; len_err pulses for 1 cycle; state stays IDLE; ident is unchanged.
- FSM states:
  - IDLE: req_ready=1. On an accepted legal request, go to CALC.
  - CALC: 10 cycles. Add one 16-bit header word per cycle (checksum field taken as 0) into a 20-bit accumulator, in header word order. Then go to FOLD.
  - FOLD: 1 cycle. CK = ~fold(fold(acc)), where fold(x) = x[15:0] + x[19:16]. Then go to SEND.
  - SEND: N = 20/DATA_BYTES beats; beat k carries header bytes k*DATA_BYTES .. k*DATA_BYTES+DATA_BYTES-1.
    - m_valid=1 throughout SEND.
    - Beat counter advances only on m_valid && m_ready.
    - m_data and m_last are held stable while m_ready=0.
    - m_last=1 only on beat N-1.
    - On acceptance of the last beat: go to IDLE and set ident <= ident+1, wrapping 16'hFFFF to 16'h0000.
- req_ready=0 in CALC, FOLD and SEND; requests are not queued.
- Latency: request accepted at cycle 0 → m_valid rises at cycle 12 (10 CALC cycles + 1 FOLD cycle, registered output). A new request can be accepted the cycle after the last beat handshake.
- m_ready may be high before m_valid; it has no effect outside SEND.
- Boundaries:
  - req_plen=65515 is legal and gives TL=16'hFFFF.
  - req_plen=0 gives TL=20.
  - Checksum fold must handle an accumulator carry of up to 4 bits.

Test Plan:
- DATA_BYTES=1, IDENT_INIT=0; request sa=C0A80001, da=C0A800C7, proto=11, plen=95; m_ready=1 → m_valid at cycle 12; 20 bytes 45 00 00 73 00 00 40 00 40 11 B8 61 C0 A8 00 01 C0 A8 00 C7; m_last on byte 20; ident becomes 1.
- DATA_BYTES=4, same request → 5 beats 0x73000045, 0x00400000, 0x61B81140, 0x0100A8C0, 0xC700A8C0; m_last on beat 5.
- Backpressure, DATA_BYTES=2: toggle m_ready randomly → the byte sequence is identical to the unstalled case; m_data is unchanged across stalled cycles; exactly 10 beats are accepted.
- plen=65516 → len_err single pulse; no m_valid; req_ready stays 1; ident unchanged. plen=65515 → TL bytes FF FF; checksum matches a software reference.
- IDENT_INIT=16'hFFFF; send two packets → ID bytes FF FF, then 00 00; checksums are correct for both.
- Drop rst_n during SEND beat 3 → m_valid=0 immediately (asynchronous); after release req_ready=1, ident=IDENT_INIT, and the next request produces a complete correct header.
